// File: rtl/vdp_bridge_pkg.sv
// Shared types and parameter defaults for the VDP CPU bridge.
// Provides the bridge FSM state enum and default synchronizer/filter/timeout sizes.
package vdp_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILTER_LEN_DEF  = 4;
    localparam int ACK_TIMEOUT_DEF = 64;

endpackage

// File: rtl/strobe_filter.sv
// One-bit synchronizer plus persistence filter for an active-low bus strobe.
// Ports: clk, reset (sync, active-high), pin (async strobe), level (filtered strobe).
module strobe_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // level only follows s after FILTER_LEN consecutive differing samples;
    // any agreeing sample clears the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '1;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vdp_cpu_bridge.sv
// Turns raw MSX bus strobes into one acknowledged VDP request per access.
// Ports: csr_n/csw_n/mode/cdo (async CPU side), cdi (read data), vdp_* (VDP port), collision/timeout pulses.
module vdp_cpu_bridge
    import vdp_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       csr_n,
    input  logic       csw_n,
    input  logic [1:0] mode,
    input  logic [7:0] cdo,
    output logic [7:0] cdi,
    output logic       vdp_req,
    output logic       vdp_wrt,
    output logic [1:0] vdp_adr,
    output logic [7:0] vdp_dbo,
    input  logic       vdp_ack,
    input  logic [7:0] vdp_dbi,
    output logic       collision,
    output logic       timeout
);

    localparam int TW = $clog2(ACK_TIMEOUT);

    state_t state, state_n;

    logic                        rd_lvl, wr_lvl;
    logic                        rd_prev, wr_prev;
    logic                        rd_fall, wr_fall;
    logic [SYNC_STAGES-1:0][1:0] mode_s;
    logic [SYNC_STAGES-1:0][7:0] cdo_s;
    logic [TW-1:0]               tcnt, tcnt_n;
    logic                        wrt_n, coll_n, to_n;
    logic [1:0]                  adr_n;
    logic [7:0]                  dbo_n, cdi_n;

    strobe_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_rd (
        .clk  (clk),
        .reset(reset),
        .pin  (csr_n),
        .level(rd_lvl)
    );

    strobe_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_wr (
        .clk  (clk),
        .reset(reset),
        .pin  (csw_n),
        .level(wr_lvl)
    );

    assign rd_fall = rd_prev & ~rd_lvl;
    assign wr_fall = wr_prev & ~wr_lvl;
    assign vdp_req = (state == REQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tcnt      <= '0;
            rd_prev   <= 1'b1;
            wr_prev   <= 1'b1;
            mode_s    <= '0;
            cdo_s     <= '0;
            vdp_wrt   <= 1'b0;
            vdp_adr   <= '0;
            vdp_dbo   <= '0;
            cdi       <= '0;
            collision <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            tcnt      <= tcnt_n;
            rd_prev   <= rd_lvl;
            wr_prev   <= wr_lvl;
            mode_s    <= {mode_s[SYNC_STAGES-2:0], mode};
            cdo_s     <= {cdo_s[SYNC_STAGES-2:0], cdo};
            vdp_wrt   <= wrt_n;
            vdp_adr   <= adr_n;
            vdp_dbo   <= dbo_n;
            cdi       <= cdi_n;
            collision <= coll_n;
            timeout   <= to_n;
        end
    end

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        wrt_n   = vdp_wrt;
        adr_n   = vdp_adr;
        dbo_n   = vdp_dbo;
        cdi_n   = cdi;
        coll_n  = 1'b0;
        to_n    = 1'b0;
        unique case (state)
            IDLE: begin
                // Any edge while both filtered strobes are low is ambiguous.
                if ((rd_fall || wr_fall) && !rd_lvl && !wr_lvl) begin
                    coll_n  = 1'b1;
                    state_n = HOLD;
                end else if (rd_fall || wr_fall) begin
                    adr_n  = mode_s[SYNC_STAGES-1];
                    wrt_n  = wr_fall;
                    if (wr_fall) begin
                        dbo_n = cdo_s[SYNC_STAGES-1];
                    end
                    tcnt_n  = '0;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (vdp_ack) begin
                    if (!vdp_wrt) begin
                        cdi_n = vdp_dbi;
                    end
                    state_n = HOLD;
                end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
                    to_n    = 1'b1;
                    state_n = HOLD;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            HOLD: begin
                if (rd_lvl && wr_lvl) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vdp_cpu_bridge.sv
// Scoreboard bench for vdp_cpu_bridge: stimulus pushes expected events, a monitor pops them.
// Ports: drives all CPU-side pins and emulates the VDP ack/data responder.
module tb_vdp_cpu_bridge;

    localparam int SYNC = 2;
    localparam int FLEN = 4;
    localparam int TOUT = 64;
    localparam int LAT  = SYNC + FLEN + 1;

    typedef struct {
        bit         coll;
        bit         wrt;
        logic [1:0] adr;
        logic [7:0] dbo;
        int         start;
        int         len;
        bit         to;
        logic [7:0] cdi;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       csr_n = 1'b1;
    logic       csw_n = 1'b1;
    logic [1:0] mode = '0;
    logic [7:0] cdo = '0;
    logic [7:0] cdi;
    logic       vdp_req;
    logic       vdp_wrt;
    logic [1:0] vdp_adr;
    logic [7:0] vdp_dbo;
    logic       vdp_ack = 1'b0;
    logic [7:0] vdp_dbi = '0;
    logic       collision;
    logic       timeout;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    exp_t       q[$];
    logic [7:0] m_dbo = '0;
    logic [7:0] m_cdi = '0;
    int         ack_delay = 0;
    logic [7:0] resp_dbi = '0;

    vdp_cpu_bridge #(
        .SYNC_STAGES(SYNC),
        .FILTER_LEN (FLEN),
        .ACK_TIMEOUT(TOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .csr_n    (csr_n),
        .csw_n    (csw_n),
        .mode     (mode),
        .cdo      (cdo),
        .cdi      (cdi),
        .vdp_req  (vdp_req),
        .vdp_wrt  (vdp_wrt),
        .vdp_adr  (vdp_adr),
        .vdp_dbo  (vdp_dbo),
        .vdp_ack  (vdp_ack),
        .vdp_dbi  (vdp_dbi),
        .collision(collision),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // VDP responder: acks in the ack_delay-th request cycle, never if negative.
    int rcnt = 0;
    always @(negedge clk) begin
        if (vdp_req && !reset) begin
            if (ack_delay >= 0 && rcnt == ack_delay) begin
                vdp_ack = 1'b1;
                vdp_dbi = resp_dbi;
            end else begin
                vdp_ack = 1'b0;
                vdp_dbi = 8'($urandom);
            end
            rcnt++;
        end else begin
            vdp_ack = 1'b0;
            rcnt    = 0;
        end
    end

    // Monitor
    exp_t cur;
    bit   have = 0;
    bit   req_q = 0;
    int   rlen = 0;
    always @(negedge clk) begin
        if (reset) begin
            have  = 0;
            req_q = 0;
        end else begin
            if (collision) begin
                if (q.size() == 0) begin
                    chk("unexpected_collision", 1, 0);
                end else begin
                    cur = q.pop_front();
                    chk("collision_expected", 32'(cur.coll), 1);
                    chk("collision_cycle", cyc, cur.start);
                end
            end
            if (vdp_req && !req_q) begin
                if (q.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    cur  = q.pop_front();
                    have = 1;
                    rlen = 0;
                    chk("req_not_collision", 32'(cur.coll), 0);
                    chk("req_cycle", cyc, cur.start);
                    chk("req_wrt", 32'(vdp_wrt), 32'(cur.wrt));
                    chk("req_adr", 32'(vdp_adr), 32'(cur.adr));
                    chk("req_dbo", 32'(vdp_dbo), 32'(cur.dbo));
                end
            end
            if (vdp_req) rlen++;
            if (!vdp_req && req_q && have) begin
                chk("req_len", rlen, cur.len);
                chk("timeout_pulse", 32'(timeout), 32'(cur.to));
                chk("cdi_after", 32'(cdi), 32'(cur.cdi));
                have = 0;
            end else if (timeout) begin
                chk("unexpected_timeout", 1, 0);
            end
            req_q = vdp_req;
        end
    end

    task automatic wait_quiet();
        int n;
        repeat (8) @(posedge clk);
        n = 0;
        while (vdp_req && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (vdp_req) chk("req_drop_bound", 1, 0);
        repeat (10) @(posedge clk);
    endtask

    // kind: 0 read, 1 write, 2 both strobes. dly < 0 means the VDP never acks.
    task automatic access(input int kind, input logic [1:0] md, input logic [7:0] d,
                          input int low, input int dly, input logic [7:0] dbi);
        exp_t e;
        @(posedge clk);
        #1;
        ack_delay = dly;
        resp_dbi  = dbi;
        mode      = md;
        cdo       = d;
        if (low >= FLEN) begin
            e.start = cyc + LAT;
            e.coll  = (kind == 2);
            e.wrt   = (kind == 1);
            e.adr   = md;
            e.to    = (dly < 0);
            e.len   = (dly < 0) ? TOUT : dly + 1;
            if (kind == 1) m_dbo = d;
            if (kind == 0 && dly >= 0) m_cdi = dbi;
            e.dbo = m_dbo;
            e.cdi = m_cdi;
            q.push_back(e);
        end
        csr_n = (kind == 1);
        csw_n = (kind == 0);
        repeat (low) @(posedge clk);
        #1;
        csr_n = 1'b1;
        csw_n = 1'b1;
        wait_quiet();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(vdp_req), 0);
        chk({tag, "_wrt"}, 32'(vdp_wrt), 0);
        chk({tag, "_adr"}, 32'(vdp_adr), 0);
        chk({tag, "_dbo"}, 32'(vdp_dbo), 0);
        chk({tag, "_cdi"}, 32'(cdi), 0);
        chk({tag, "_coll"}, 32'(collision), 0);
        chk({tag, "_to"}, 32'(timeout), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   kind;
        int   r;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // Directed write, then read, then write keeping cdi.
        access(1, 2'd1, 8'hA5, 20, 2, 8'h00);
        access(0, 2'd0, 8'h11, 12, 1, 8'h3C);
        access(1, 2'd3, 8'h5A, 10, 0, 8'h77);

        // Glitch boundary.
        access(0, 2'd2, 8'h00, FLEN - 1, 1, 8'hEE);
        access(0, 2'd2, 8'h00, FLEN, 1, 8'h42);

        // Collision, with a re-fall of csr_n while still in HOLD.
        @(posedge clk);
        #1;
        e.start = cyc + LAT;
        e.coll  = 1;
        q.push_back(e);
        csr_n = 1'b0;
        csw_n = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        csr_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        csr_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        csr_n = 1'b1;
        csw_n = 1'b1;
        wait_quiet();

        // No ack, last-cycle ack, immediate ack.
        access(1, 2'd2, 8'hC3, 6, -1, 8'h99);
        access(0, 2'd1, 8'h00, 6, TOUT - 1, 8'h81);
        access(0, 2'd3, 8'h00, 6, 0, 8'h18);

        // Reset while a request is outstanding.
        @(posedge clk);
        #1;
        ack_delay = -1;
        mode      = 2'd2;
        cdo       = 8'h66;
        e.start   = cyc + LAT;
        e.coll    = 0;
        e.wrt     = 1;
        e.adr     = 2'd2;
        e.dbo     = 8'h66;
        q.push_back(e);
        csw_n = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #1;
        reset = 1'b1;
        csw_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("midreq_reset");
        reset = 1'b0;
        m_dbo = '0;
        m_cdi = '0;
        repeat (10) @(posedge clk);
        access(0, 2'd1, 8'h00, 8, 3, 8'hD2);

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            r    = $urandom_range(0, 5);
            kind = (r < 3) ? 0 : (r < 5) ? 1 : 2;
            r    = $urandom_range(0, 9);
            access(kind, 2'($urandom), 8'($urandom),
                   $urandom_range(2, 16), (r == 9) ? -1 : r, 8'($urandom));
        end

        repeat (5) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
